gray_monitor: RTL and testbench

- Downstream consumer of the 3-bit Gray-code counter stage: samples its Gray output and Overflow flag.
- Converts Gray to binary.
- Checks that every sampled transition is a legal +1 Gray step and counts wrap-arounds.
- Raises a sticky Error on any illegal sequence; used as the on-chip checker/decoder for the counter.

---
 rtl/gray_pkg.sv | 22 ++
 rtl/gray2bin.sv | 19 +
 rtl/gray_monitor.sv | 113 +++++++++++
 tb/tb_gray_monitor.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the 3-bit Gray counter and its downstream monitor:
// monitor state encoding, default code width and the Gray code sequence.
package gray_pkg;

   localparam int GRAY_WIDTH = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_TRACK = 2'b01,
      ST_ERROR = 2'b10
   } state_t;

   localparam logic [2:0] G0 = 3'b000;
   localparam logic [2:0] G1 = 3'b001;
   localparam logic [2:0] G2 = 3'b011;
   localparam logic [2:0] G3 = 3'b010;
   localparam logic [2:0] G4 = 3'b110;
   localparam logic [2:0] G5 = 3'b111;
   localparam logic [2:0] G6 = 3'b101;
   localparam logic [2:0] G7 = 3'b100;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all
// Gray bits at or above its position.
module gray2bin
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_WIDTH
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] binary
);

   always_comb begin
      binary = '0;
      for (int i = 0; i < WIDTH; i++) begin
         binary[i] = ^(gray >> i);
      end
   end

endmodule

// File: rtl/gray_monitor.sv
// Checker/decoder for the upstream Gray counter: decodes, verifies +1 steps,
// counts wraps and latches a sticky error. Optional overflow cross-check under
// GRAY_MONITOR_OVF_CHECK_EN.
//
//   state    | meaning
//   ST_IDLE  | waiting for the first sample after reset
//   ST_TRACK | following the counter, checking every sample
//   ST_ERROR | illegal sequence seen; frozen until reset
module gray_monitor
   import gray_pkg::*;
#(
   parameter int WIDTH  = GRAY_WIDTH,
   parameter int WRAP_W = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              En,
   input  logic [WIDTH-1:0]  Gray,
   input  logic              Overflow_in,
   output logic [WIDTH-1:0]  Binary,
   output logic              Step,
   output logic [WRAP_W-1:0] WrapCount,
   output logic              Error,
   output logic              Busy
);

   localparam logic [WIDTH-1:0]  ONE   = 1;
   localparam logic [WRAP_W-1:0] ONE_W = 1;

   state_t              state, state_nxt;
   logic [WIDTH-1:0]    prev, prev_nxt, conv;
   logic [WRAP_W-1:0]   wrap_nxt, wrap_inc;
   logic                step_nxt, err_nxt;
   logic                is_hold, is_inc, is_wrap, ovf_bad;

   gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
      .gray   (Gray),
      .binary (conv)
   );

   assign is_hold  = (conv == prev);
   assign is_inc   = (conv == prev + ONE);
   assign is_wrap  = is_inc && (prev == '1);
   assign wrap_inc = (WrapCount == '1) ? WrapCount : WrapCount + ONE_W;

`ifdef GRAY_MONITOR_OVF_CHECK_EN
   assign ovf_bad = (Overflow_in != ((WrapCount != '0) || is_wrap));
`else
   logic ovf_unused;
   assign ovf_unused = Overflow_in;
   assign ovf_bad    = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      prev_nxt  = prev;
      wrap_nxt  = WrapCount;
      err_nxt   = Error;
      step_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (En) begin
               prev_nxt  = conv;
               state_nxt = ST_TRACK;
`ifdef GRAY_MONITOR_OVF_CHECK_EN
               // upstream already overflowed before we started watching
               if (Overflow_in) wrap_nxt = ONE_W;
`endif
            end
         end
         ST_TRACK: begin
            if (En) begin
               if (!ovf_bad && is_hold) begin
                  state_nxt = ST_TRACK;
               end else if (!ovf_bad && is_inc) begin
                  step_nxt = 1'b1;
                  prev_nxt = conv;
                  if (is_wrap) wrap_nxt = wrap_inc;
               end else begin
                  err_nxt   = 1'b1;
                  state_nxt = ST_ERROR;
               end
            end
         end
         ST_ERROR: begin
            state_nxt = ST_ERROR;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= ST_IDLE;
         prev      <= '0;
         Step      <= 1'b0;
         WrapCount <= '0;
         Error     <= 1'b0;
      end else begin
         state     <= state_nxt;
         prev      <= prev_nxt;
         Step      <= step_nxt;
         WrapCount <= wrap_nxt;
         Error     <= err_nxt;
      end
   end

   assign Binary = prev;
   assign Busy   = (state == ST_TRACK);

endmodule

// File: tb/tb_gray_monitor.sv
// Bench for gray_monitor: directed scenarios then random traffic, checked
// against a table-lookup reference model; a WRAP_W=2 copy checks saturation.
module tb_gray_monitor;

   logic       Clk = 1'b0;
   logic       Reset, En, Overflow_in;
   logic [2:0] Gray;

   logic [2:0] bin_a, bin_b;
   logic       step_a, step_b, err_a, err_b, busy_a, busy_b;
   logic [7:0] wrap_a;
   logic [1:0] wrap_b;

   gray_monitor #(.WIDTH(3), .WRAP_W(8)) u_a (
      .Clk(Clk), .Reset(Reset), .En(En), .Gray(Gray), .Overflow_in(Overflow_in),
      .Binary(bin_a), .Step(step_a), .WrapCount(wrap_a), .Error(err_a), .Busy(busy_a)
   );

   gray_monitor #(.WIDTH(3), .WRAP_W(2)) u_b (
      .Clk(Clk), .Reset(Reset), .En(En), .Gray(Gray), .Overflow_in(Overflow_in),
      .Binary(bin_b), .Step(step_b), .WrapCount(wrap_b), .Error(err_b), .Busy(busy_b)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   // reference model state: index in the Gray sequence, number of wraps seen
   int m_on, m_dead, m_prev, m_wraps, m_step, m_err;
   int gtab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

   function automatic int dec(input logic [2:0] g);
      for (int i = 0; i < 8; i++) if (gtab[i] == int'(g)) return i;
      return 0;
   endfunction

   function automatic logic [2:0] enc(input int i);
      return 3'(gtab[i % 8]);
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic logic exp_ovf(input logic [2:0] g);
      return (m_wraps != 0) || (m_on == 1 && m_dead == 0 && m_prev == 7 && dec(g) == 0);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rst, input logic en, input logic [2:0] g, input logic ovf);
      int  b;
      bit  inc, wrapstep, bad;
      Reset = rst; En = en; Gray = g; Overflow_in = ovf;
      m_step = 0;
      if (rst) begin
         m_on = 0; m_dead = 0; m_prev = 0; m_wraps = 0; m_err = 0;
      end else if (m_dead == 0 && m_on == 0) begin
         if (en) begin
            m_on   = 1;
            m_prev = dec(g);
`ifdef GRAY_MONITOR_OVF_CHECK_EN
            if (ovf) m_wraps = 1;
`endif
         end
      end else if (m_dead == 0 && en) begin
         b        = dec(g);
         inc      = (b == (m_prev + 1) % 8);
         wrapstep = inc && (m_prev == 7);
         bad      = 0;
`ifdef GRAY_MONITOR_OVF_CHECK_EN
         bad = (ovf != ((m_wraps != 0) || wrapstep));
`endif
         if (bad || !(inc || b == m_prev)) begin
            m_dead = 1; m_err = 1;
         end else if (inc) begin
            m_step = 1; m_prev = b;
            if (wrapstep) m_wraps++;
         end
      end
      @(posedge Clk);
      #1;
      chk("binary",  32'(bin_a),  32'(m_prev));
      chk("step",    32'(step_a), 32'(m_step));
      chk("wrap_a",  32'(wrap_a), 32'(sat(m_wraps, 255)));
      chk("wrap_b",  32'(wrap_b), 32'(sat(m_wraps, 3)));
      chk("error",   32'(err_a),  32'(m_err));
      chk("busy",    32'(busy_a), 32'(m_on == 1 && m_dead == 0));
      chk("error_b", 32'(err_b),  32'(m_err));
   endtask

   task automatic go(input logic [2:0] g);
      step(1'b0, 1'b1, g, exp_ovf(g));
   endtask

   task automatic rst();
      step(1'b1, 1'b0, 3'b000, 1'b0);
   endtask

   initial begin
      Reset = 1'b1; En = 1'b0; Gray = '0; Overflow_in = 1'b0;
      m_on = 0; m_dead = 0; m_prev = 0; m_wraps = 0; m_step = 0; m_err = 0;
      rst();
      rst();

      // basic stepping and a full wrap
      go(3'b000); go(3'b001); go(3'b011); go(3'b010);
      chk("tp_bin3", 32'(bin_a), 32'd3);
      go(3'b110); go(3'b111); go(3'b101); go(3'b100);
      chk("tp_bin7", 32'(bin_a), 32'd7);
      go(3'b000);
      chk("tp_wrap1", 32'(wrap_a), 32'd1);

      // 300 steps: 37 wraps, narrow copy saturates
      rst();
      go(3'b000);
      for (int i = 1; i <= 300; i++) go(enc(i));
      chk("wrap37", 32'(wrap_a), 32'd37);
      chk("wrap_sat", 32'(wrap_b), 32'd3);

      // skip from 001 to 010 is illegal; later legal codes ignored
      rst();
      go(3'b000); go(3'b001); go(3'b010);
      chk("skip_err", 32'(err_a), 32'd1);
      chk("skip_bin", 32'(bin_a), 32'd1);
      go(3'b011); go(3'b010); go(3'b110);
      chk("frozen_bin", 32'(bin_a), 32'd1);
      rst();
      chk("post_rst_err", 32'(err_a), 32'd0);

      // backward step is illegal
      go(3'b011); go(3'b001);

      // hold, then En=0 with a changing Gray
      rst();
      go(3'b000); go(3'b001); go(3'b011);
      for (int i = 0; i < 5; i++) go(3'b011);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      chk("hold_bin", 32'(bin_a), 32'd2);

      // reset beats En with an illegal code
      go(3'b010);
      step(1'b1, 1'b1, 3'b100, 1'b1);
      chk("rst_wins_busy", 32'(busy_a), 32'd0);

      // overflow flag scenarios (checked only when the feature is built in)
      rst();
      go(3'b000); go(3'b001);
      step(1'b0, 1'b1, 3'b011, 1'b1);
      rst();
      go(3'b000);
      for (int i = 1; i < 8; i++) go(enc(i));
      step(1'b0, 1'b1, 3'b000, 1'b1);
      chk("ovf_wrap", 32'(wrap_a), 32'd1);
      chk("ovf_wrap_err", 32'(err_a), 32'd0);
      rst();
      step(1'b0, 1'b1, 3'b101, 1'b1);
      go(3'b100); go(3'b000); go(3'b001);

      // random traffic
      rst();
      for (int n = 0; n < 1500; n++) begin
         automatic int         r   = int'($urandom_range(0, 99));
         automatic logic       en  = ($urandom_range(0, 3) != 0);
         automatic logic [2:0] g;
         automatic logic       ovf;
         if (r < 2) begin
            step(1'b1, en, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         end else begin
            if (m_on == 1 && m_dead == 0 && r < 72)      g = enc(m_prev + 1);
            else if (m_on == 1 && m_dead == 0 && r < 92) g = enc(m_prev);
            else                                          g = 3'($urandom_range(0, 7));
            ovf = exp_ovf(g);
            if (r < 6) ovf = ~ovf;
            if (m_on == 0) ovf = (r < 10);
            step(1'b0, en, g, ovf);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
